// File: rtl/cnn_pkg.sv
// cnn_pkg: shared image geometry, FSM state type and slot helper for the window fetcher.
package cnn_pkg;
    localparam int IMG_W = 28;
    localparam int WIN = 3;
    localparam int OUT_W = IMG_W - WIN + 1;
    localparam int WORDS_PER_ROW = 7;
    localparam int IMG_WORDS = IMG_W * WORDS_PER_ROW;

    typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

    // Line-buffer slots rotate 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] slot_inc(input logic [1:0] s);
        return s == 2'd2 ? 2'd0 : s + 2'd1;
    endfunction
endpackage

// File: rtl/row_line_buffer.sv
// row_line_buffer: three circular image rows, 4-byte word writes, 3x3 tap read at a column.
module row_line_buffer
    import cnn_pkg::*;
(
    input  logic        clk,
    input  logic        wr_en,
    input  logic [1:0]  wr_slot,
    input  logic [2:0]  wr_word,
    input  logic [31:0] wr_data,
    input  logic [1:0]  rd_top,
    input  logic [4:0]  rd_col,
    output logic [71:0] taps
);
    logic [7:0] mem [3][IMG_W];
    logic [1:0] sl [3];

    always_ff @(posedge clk)
        if (wr_en)
            for (int k = 0; k < 4; k++)
                mem[wr_slot][{wr_word, 2'(k)}] <= wr_data[8*k +: 8];

    assign sl[0] = rd_top;
    assign sl[1] = slot_inc(rd_top);
    assign sl[2] = slot_inc(sl[1]);

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign taps[8*(3*r+c) +: 8] = mem[sl[r]][rd_col + 5'(c)];
        end
    end
endmodule

// File: rtl/conv_window_fetch.sv
// conv_window_fetch: streams 3x3 windows of a 28x28 image read from four external byte banks.
module conv_window_fetch
    import cnn_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        ram_rden,
    output logic [7:0]  ram_addr,
    input  logic [7:0]  ram_q0,
    input  logic [7:0]  ram_q1,
    input  logic [7:0]  ram_q2,
    input  logic [7:0]  ram_q3,
    output logic        win_valid,
    input  logic        win_ready,
    output logic [71:0] win_data,
    output logic [4:0]  win_row,
    output logic [4:0]  win_col
);
    state_t state;
    logic [2:0] fcnt;
    logic [1:0] wslot, top, rd_top;
    logic [4:0] rd_col;
    logic priming;
    logic [71:0] taps;

    // Taps are read one step ahead so win_data can be registered alongside win_valid.
    always_comb begin
        rd_top = state == FILL && !priming ? slot_inc(top) : top;
        rd_col = state == EMIT && win_col != 5'(OUT_W - 1) ? win_col + 5'd1 : 5'd0;
    end

    row_line_buffer u_lb (
        .clk(clk),
        .wr_en(state == FILL && fcnt != 3'd0),
        .wr_slot(wslot),
        .wr_word(fcnt - 3'd1),
        .wr_data({ram_q3, ram_q2, ram_q1, ram_q0}),
        .rd_top(rd_top),
        .rd_col(rd_col),
        .taps(taps)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            win_valid <= 1'b0;
            ram_rden <= 1'b0;
            ram_addr <= '0;
            win_row <= '0;
            win_col <= '0;
            win_data <= '0;
            fcnt <= '0;
            wslot <= '0;
            top <= '0;
            priming <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= FILL;
                    busy <= 1'b1;
                    ram_rden <= 1'b1;
                    ram_addr <= '0;
                    fcnt <= '0;
                    wslot <= '0;
                    top <= '0;
                    priming <= 1'b1;
                    win_row <= '0;
                    win_col <= '0;
                end
                FILL: begin
                    fcnt <= fcnt + 3'd1;
                    ram_rden <= fcnt <= 3'd5;
                    if (fcnt <= 3'd5)
                        ram_addr <= ram_addr + 8'd1;
                    if (fcnt == 3'(WORDS_PER_ROW)) begin
                        if (priming && wslot != 2'd2) begin
                            wslot <= wslot + 2'd1;
                            ram_rden <= 1'b1;
                            ram_addr <= ram_addr + 8'd1;
                        end else begin
                            state <= EMIT;
                            priming <= 1'b0;
                            win_valid <= 1'b1;
                            win_col <= '0;
                            win_data <= taps;
                            if (!priming) begin
                                top <= slot_inc(top);
                                win_row <= win_row + 5'd1;
                            end
                        end
                    end
                end
                EMIT: if (win_ready) begin
                    if (win_col != 5'(OUT_W - 1)) begin
                        win_col <= win_col + 5'd1;
                        win_data <= taps;
                    end else begin
                        win_valid <= 1'b0;
                        if (win_row == 5'(OUT_W - 1)) begin
                            state <= DONE;
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            // Next image row overwrites the oldest resident row.
                            state <= FILL;
                            fcnt <= '0;
                            wslot <= top;
                            ram_rden <= 1'b1;
                            ram_addr <= ram_addr + 8'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_window_fetch.sv
// tb_conv_window_fetch: directed frames with ramp and random images checked against an image-level window model.
module tb_conv_window_fetch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic win_ready = 1'b1;
    logic busy, done, ram_rden, win_valid;
    logic [7:0] ram_addr;
    logic [7:0] qbank [4];
    logic [71:0] win_data;
    logic [4:0] win_row, win_col;
    logic [7:0] img [28][28];
    int n_asrt = 0;
    int n_fail = 0;
    bit ramp;

    always #5 clk = ~clk;

    conv_window_fetch dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .ram_rden(ram_rden), .ram_addr(ram_addr),
        .ram_q0(qbank[0]), .ram_q1(qbank[1]), .ram_q2(qbank[2]), .ram_q3(qbank[3]),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_row(win_row), .win_col(win_col)
    );

    // External banks: word w of bank k holds pixel (w/7, 4*(w%7)+k), one-cycle read latency.
    always @(posedge clk)
        if (ram_rden && ram_addr < 8'd196)
            for (int k = 0; k < 4; k++)
                qbank[k] <= img[int'(ram_addr) / 7][4 * (int'(ram_addr) % 7) + k];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int r, input int c);
        logic [71:0] w;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                w[8*(3*dr+dc) +: 8] = img[r+dr][c+dc];
        return w;
    endfunction

    task automatic load_img(input bit use_ramp);
        ramp = use_ramp;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img[r][c] = use_ramp ? 8'((r * 28 + c) % 256) : 8'($urandom_range(0, 255));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, win_valid, 0);
        chk({tag, "_rden"}, ram_rden, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_row"}, win_row, 0);
        chk({tag, "_col"}, win_col, 0);
        chk({tag, "_data"}, win_data, 0);
    endtask

    // mode 0: ready high, 1: toggling, 2: 10-cycle stall at (0,25), 3: random ready
    task automatic run_frame(input int mode, input bit repulse, input int rst_at);
        int idx = 0, exp_addr = 0, first_v = -1, last_x = -1, done_c = -1, stall = 0;
        @(negedge clk);
        start = 1'b1;
        win_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 4000; cyc++) begin
            if (cyc == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk_idle_zero("midrst");
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("midrst_no_done", done, 0);
                end
                return;
            end
            start = repulse && cyc == 100;
            case (mode)
                0: win_ready = 1'b1;
                1: win_ready = ~win_ready;
                2: if (win_valid && win_row == 0 && win_col == 25 && stall < 10) begin
                    win_ready = 1'b0;
                    stall++;
                end else win_ready = 1'b1;
                default: win_ready = 1'($urandom_range(0, 1));
            endcase
            if (done) begin
                done_c = cyc;
                chk("busy_at_done", busy, 0);
                break;
            end
            chk("busy", busy, 1);
            if (cyc <= 24)
                chk("prime_rden", ram_rden, ((cyc - 1) % 8) < 7);
            chk("rden_vs_valid", ram_rden & win_valid, 0);
            if (ram_rden) begin
                chk("addr", ram_addr, 72'(exp_addr));
                exp_addr++;
            end
            if (win_valid) begin
                if (first_v < 0) first_v = cyc;
                if (idx < 676) begin
                    chk("win_row", win_row, 72'(idx / 26));
                    chk("win_col", win_col, 72'(idx % 26));
                    chk("win_data", win_data, exp_win(idx / 26, idx % 26));
                    if (ramp && idx == 0) chk("ramp_win00", win_data, 72'h3A39381E1D1C020100);
                    if (ramp && idx == 675) chk("ramp_centre", win_data[39:32], 8'hF2);
                end else chk("extra_window", 1, 0);
                if (win_ready) begin
                    idx++;
                    last_x = cyc;
                end
            end
            @(negedge clk);
        end
        chk("done_seen", done_c > 0, 1);
        chk("n_windows", 72'(idx), 676);
        chk("n_addr", 72'(exp_addr), 196);
        if (mode == 2) chk("stall_len", 72'(stall), 10);
        if (mode == 0) begin
            chk("first_valid_cyc", 72'(first_v), 25);
            chk("last_xfer_cyc", 72'(last_x), 900);
            chk("done_cyc", 72'(done_c), 901);
        end
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        load_img(1'b1);
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_beats_start", busy, 0);
        chk("rst_beats_start_rden", ram_rden, 0);
        run_frame(0, 1'b0, 0);
        run_frame(1, 1'b0, 0);
        run_frame(2, 1'b0, 0);
        run_frame(0, 1'b1, 0);
        run_frame(0, 1'b0, 300);
        repeat (4) @(negedge clk);
        run_frame(0, 1'b0, 0);
        load_img(1'b0);
        run_frame(3, 1'b0, 0);
        run_frame(0, 1'b0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/conv_window_fetch.md
CONV_WINDOW_FETCH -- requirements
Module: conv_window_fetch

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock domain; all logic is rising-edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-high.
REQ-003 SHALL have `start`, input, 1 bit: single-cycle pulse that begins a frame.
REQ-004 SHALL have `busy`, output, 1 bit: high from frame accept until `done`.
REQ-005 SHALL have `done`, output, 1 bit: one-cycle pulse at end of frame.
REQ-006 SHALL have `ram_rden`, output, 1 bit: read enable shared by the four image banks.
REQ-007 SHALL have `ram_addr`, output, 8 bits: word address shared by the four banks, range 0..195.
REQ-008 SHALL have `ram_q0`..`ram_q3`, input, 8 bits each: bank read data, valid one cycle after `ram_rden`.
REQ-009 SHALL have `win_valid`, output, 1 bit; `win_ready`, input, 1 bit: window handshake.
REQ-010 SHALL have `win_data`, output, 72 bits: 3x3 window; pixel (dr,dc) at bits [8*(3*dr+dc)+7 : 8*(3*dr+dc)].
REQ-011 SHALL have `win_row` and `win_col`, outputs, 5 bits each: top-left coordinate of the window, range 0..25.

Function
REQ-012 Image SHALL be 28x28 bytes; pixel (r,c) SHALL be at word 7r+c/4 of bank c%4; bank0 holds the leftmost pixel of each word.
REQ-013 FSM states SHALL be IDLE, FILL, EMIT, DONE.
REQ-014 In IDLE, `start`=1 SHALL move the FSM to FILL on the next edge; `start` SHALL be ignored in all other states.
REQ-015 A FILL of one image row SHALL last exactly 8 cycles: `ram_rden`=1 with `ram_addr`=7r+w for w=0..6 on cycles 0..6, and capture of `ram_q*` on cycles 1..7.
REQ-016 The initial FILL SHALL load rows 0, 1 and 2 back-to-back (24 cycles), then enter EMIT.
REQ-017 EMIT SHALL present windows for columns 0..25 of the current output row; a transfer occurs when `win_valid` and `win_ready` are both high.
REQ-018 With `win_ready` held high, EMIT SHALL sustain one transfer per cycle.
REQ-019 While `win_valid`=1 and `win_ready`=0, `win_data`, `win_row` and `win_col` SHALL hold stable.
REQ-020 On transfer of column 25:
  - output row < 25: the FSM SHALL go to FILL of image row (output row + 3), overwriting the oldest line-buffer row.
  - output row = 25: the FSM SHALL go to DONE.
REQ-021 The line buffer SHALL be circular; `win_data` row dr=0 SHALL always be the topmost of the three resident rows.
REQ-022 DONE SHALL last one cycle with `done`=1 and `busy`=0, then return to IDLE.
REQ-023 `win_valid` SHALL be 0 outside EMIT; `ram_rden` SHALL be 0 outside the issue cycles of FILL.
REQ-024 A frame SHALL produce exactly 676 windows in raster order.
REQ-025 With `win_ready`=1 throughout, the first `win_valid` SHALL be at cycle 25 after the start edge, the last transfer at cycle 900, and `done` at cycle 901.

Reset
REQ-026 Reset SHALL force:
  - state IDLE;
  - `busy`, `done`, `win_valid` and `ram_rden` to 0;
  - `ram_addr`, `win_row`, `win_col` and `win_data` to 0.
REQ-027 Reset mid-frame SHALL abandon the frame; no `done` SHALL be produced, and line-buffer contents need not be cleared.
REQ-028 If `reset` and `start` are high in the same cycle, reset SHALL win.

Structure
REQ-029 Package `cnn_pkg` SHALL hold:
  - constants IMG_W=28, WIN=3, OUT_W=26, WORDS_PER_ROW=7, IMG_WORDS=196;
  - the FSM state enum.
REQ-030 The three-row storage SHALL be a sub-module `row_line_buffer`, with a 4-byte row write port and a 3x3 tap read at a column index.
REQ-031 The block SHALL instantiate no RAM; the image banks are external.

Verification
REQ-032 Ramp image, pixel(r,c)=(r*28+c) mod 256, `win_ready`=1 -> window (0,0)={00,01,02,1C,1D,1E,38,39,3A}; window (25,25) centre byte 0xF2; first `win_valid` at cycle 25; `done` at cycle 901.
REQ-033 `win_ready` toggling every cycle -> the same 676 windows in order, each stable while stalled.
REQ-034 `win_ready`=0 for 10 cycles on column 25 of row 0 -> window held, `ram_rden` stays 0, FILL of row 3 starts only after the transfer.
REQ-035 `ram_addr` trace -> 0..20 back-to-back, then 21..27 after 26 transfers, ..., final 189..195; never above 195.
REQ-036 `start` re-pulsed at cycle 100 -> ignored; output identical to REQ-032.
REQ-037 `reset` at cycle 300, new `start` later -> all outputs 0 the cycle after reset; the new frame repeats REQ-032 exactly.
